// File: rtl/mc_core.sv
// mc_core: multicycle MIPS-subset core.
// Each instruction steps through FETCH / DECODE / EXEC / MEM / WB.
// Instruction memory is read combinationally at the PC.
// Data memory is reached through a req/ack handshake that may stretch MEM.
// Optional trace outputs (retire, retire_pc, icount) exist only when the
// macro MC_CORE_TRACE_EN is defined.
module mc_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic [REG_AW-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [2:0]        state_o,
  output logic              halted,
  output logic              illegal
`ifdef MC_CORE_TRACE_EN
  ,
  output logic              retire,
  output logic [PC_W-1:0]   retire_pc,
  output logic [31:0]       icount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int NREGS = 2 ** REG_AW;

  state_t             r_state;
  state_t             w_stateNext;
  logic [PC_W-1:0]    r_pc;
  logic [31:0]        r_ir;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_aluOut;
  logic [DATA_W-1:0]  r_mdr;
  logic               r_illegal;
  logic [DATA_W-1:0]  r_regs [NREGS];

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [REG_AW-1:0]  w_rs;
  logic [REG_AW-1:0]  w_rt;
  logic [REG_AW-1:0]  w_rd;
  logic [31:0]        w_imm32;
  logic [DATA_W-1:0]  w_imm;
  logic               w_isRtype;
  logic               w_isJ;
  logic               w_isBeq;
  logic               w_isAddi;
  logic               w_isLw;
  logic               w_isSw;
  logic               w_functOk;
  logic               w_legal;
  logic               w_slt;
  logic [DATA_W-1:0]  w_aluResult;
  logic [REG_AW-1:0]  w_wbAddr;
  logic [DATA_W-1:0]  w_wbData;
  logic               w_wbEn;
  logic               w_memDone;
  logic               w_unused;

  // Instruction field extraction; register numbers use the low bits of each field.
  assign w_op     = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  assign w_rs     = r_ir[21 +: REG_AW];
  assign w_rt     = r_ir[16 +: REG_AW];
  assign w_rd     = r_ir[11 +: REG_AW];
  assign w_imm32  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm    = w_imm32[DATA_W-1:0];

  assign w_isRtype = (w_op == OP_RTYPE);
  assign w_isJ     = (w_op == OP_J);
  assign w_isBeq   = (w_op == OP_BEQ);
  assign w_isAddi  = (w_op == OP_ADDI);
  assign w_isLw    = (w_op == OP_LW);
  assign w_isSw    = (w_op == OP_SW);

  assign w_functOk = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                     (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                     (w_funct == FN_SLT);

  assign w_legal = (w_isRtype && w_functOk) || w_isJ || w_isBeq ||
                   w_isAddi || w_isLw || w_isSw;

  // A data access only completes when the core is running; a stalled ack is dropped.
  assign w_memDone = run && dmem_ack && (r_state == S_MEM);

  assign w_slt = ($signed(r_a) < $signed(r_b));

  // ALU: R-type operations on A/B, everything else computes A + imm.
  always_comb begin
    w_aluResult = r_a + w_imm;
    if (w_isRtype) begin
      case (w_funct)
        FN_ADD:  w_aluResult = r_a + r_b;
        FN_SUB:  w_aluResult = r_a - r_b;
        FN_AND:  w_aluResult = r_a & r_b;
        FN_OR:   w_aluResult = r_a | r_b;
        FN_SLT:  w_aluResult = {{(DATA_W-1){1'b0}}, w_slt};
        default: w_aluResult = r_a + r_b;
      endcase
    end
  end

  // Write-back target and data: rd for R-type, rt for addi/lw, MDR for loads.
  always_comb begin
    w_wbAddr = w_rt;
    w_wbData = r_aluOut;
    if (w_isRtype) begin
      w_wbAddr = w_rd;
    end
    if (w_isLw) begin
      w_wbData = r_mdr;
    end
  end

  // Register 0 is never written so it always reads back as zero.
  assign w_wbEn = run && (r_state == S_WB) && (w_wbAddr != '0);

  // FSM next-state: holds while run is low, otherwise walks the instruction phases.
  always_comb begin
    w_stateNext = r_state;
    if (run) begin
      case (r_state)
        S_FETCH: begin
          w_stateNext = S_DECODE;
        end
        S_DECODE: begin
          if (!w_legal) begin
            w_stateNext = S_HALT;
          end else if (w_isJ) begin
            w_stateNext = S_FETCH;
          end else begin
            w_stateNext = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_isBeq) begin
            w_stateNext = S_FETCH;
          end else if (w_isLw || w_isSw) begin
            w_stateNext = S_MEM;
          end else begin
            w_stateNext = S_WB;
          end
        end
        S_MEM: begin
          if (w_memDone) begin
            w_stateNext = w_isLw ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          w_stateNext = S_FETCH;
        end
        S_HALT: begin
          w_stateNext = S_HALT;
        end
        default: begin
          w_stateNext = S_HALT;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result, MDR and the illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_aluOut  <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
    end else if (run) begin
      case (r_state)
        S_FETCH: begin
          r_ir <= imem_rdata;
          r_pc <= r_pc + PC_W'(1);
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          if (w_isJ) begin
            r_pc <= r_ir[PC_W-1:0];
          end
          if (!w_legal) begin
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_aluOut <= w_aluResult;
          if (w_isBeq && (r_a == r_b)) begin
            r_pc <= r_pc + w_imm32[PC_W-1:0];
          end
        end
        S_MEM: begin
          if (w_memDone && w_isLw) begin
            r_mdr <= dmem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register file: cleared on reset, written only in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbEn) begin
      r_regs[w_wbAddr] <= w_wbData;
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req && w_isSw;
  assign dmem_addr  = r_aluOut;
  assign dmem_wdata = r_b;
  assign dbg_rd     = r_regs[dbg_ra];
  assign state_o    = r_state;
  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;

  // Instruction bits outside the decoded fields are intentionally ignored.
  assign w_unused = ^{r_ir, w_imm32};

`ifdef MC_CORE_TRACE_EN
  logic [PC_W-1:0] r_instPc;
  logic [31:0]     r_icount;
  logic            w_retire;

  // An instruction retires in its last cycle: j in DECODE, beq in EXEC,
  // sw when its access is acknowledged, everything else in WB.
  always_comb begin
    w_retire = 1'b0;
    if (run) begin
      case (r_state)
        S_DECODE: w_retire = w_isJ;
        S_EXEC:   w_retire = w_isBeq;
        S_MEM:    w_retire = w_memDone && w_isSw;
        S_WB:     w_retire = 1'b1;
        default:  w_retire = 1'b0;
      endcase
    end
  end

  // Remember the fetch address of the current instruction and count retirements, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instPc <= '0;
      r_icount <= '0;
    end else begin
      if (run && (r_state == S_FETCH)) begin
        r_instPc <= r_pc;
      end
      if (w_retire && (r_icount != 32'hFFFF_FFFF)) begin
        r_icount <= r_icount + 32'd1;
      end
    end
  end

  assign retire    = w_retire;
  assign retire_pc = r_instPc;
  assign icount    = r_icount;
`endif

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: self-checking bench for mc_core.
// Directed programs, a table of ALU vectors, stall/reset corner cases and
// random programs compared against an instruction-level reference model.
module tb_mc_core;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int PC_W   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b1;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  logic [REG_AW-1:0] dbg_ra = '0;
  logic [DATA_W-1:0] dbg_rd;
  logic [2:0]        state_o;
  logic              halted;
  logic              illegal;

  logic [31:0] imem [256];
  logic [7:0]  dmem [256];
  logic [7:0]  mReg [8];
  logic [7:0]  mMem [256];
  logic        memClr = 1'b1;
  int          ackDelay = 0;
  int          ackCnt;

  int passCount = 0;
  int totalCount = 0;

  int storeCycles, storeChanges, loadCycles;
  logic [7:0] storeAddr, storeData;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] funct;
    logic [7:0] expR3;
    int         expCycles;
  } aluVec_t;

  aluVec_t vecs [9];

`ifdef MC_CORE_TRACE_EN
  logic        retire;
  logic [7:0]  retirePc;
  logic [31:0] icount;
  int          retireCount;
  int          retirePcBad;
`endif

  always #5 clk = ~clk;

  mc_core #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .dbg_ra     (dbg_ra),
    .dbg_rd     (dbg_rd),
    .state_o    (state_o),
    .halted     (halted),
    .illegal    (illegal)
`ifdef MC_CORE_TRACE_EN
    ,
    .retire     (retire),
    .retire_pc  (retirePc),
    .icount     (icount)
`endif
  );

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = dmem_req && (ackCnt >= ackDelay);

  // Data memory responder: acks after ackDelay waiting cycles, stores on a consumed ack.
  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      ackCnt <= 0;
    end else if (!dmem_req) begin
      ackCnt <= 0;
    end else if (dmem_ack && run && !rst) begin
      ackCnt <= 0;
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end else begin
      ackCnt <= ackCnt + 1;
    end
  end

`ifdef MC_CORE_TRACE_EN
  // Count retire pulses and check each reported PC against the sequential program order.
  always @(negedge clk) begin
    if (rst) begin
      retireCount <= 0;
      retirePcBad <= 0;
    end else if (retire) begin
      if (retirePc != retireCount[7:0]) retirePcBad <= retirePcBad + 1;
      retireCount <= retireCount + 1;
    end
  end
`endif

  function automatic logic [31:0] encR(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearImem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic doReset();
    rst = 1'b1;
    run = 1'b1;
    memClr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    memClr = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runUntilHalt(input int budget, output int cycles);
    logic firstStore;
    cycles = 0;
    storeCycles = 0;
    storeChanges = 0;
    loadCycles = 0;
    firstStore = 1'b1;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dmem_req && dmem_we) begin
        if (firstStore) begin
          storeAddr = dmem_addr;
          storeData = dmem_wdata;
          firstStore = 1'b0;
        end else if (dmem_addr != storeAddr || dmem_wdata != storeData) begin
          storeChanges++;
        end
        storeCycles++;
      end
      if (dmem_req && !dmem_we) loadCycles++;
    end
  endtask

  task automatic readReg(input int idx, output logic [7:0] v);
    dbg_ra = 3'(idx);
    #1;
    v = dbg_rd;
  endtask

  task automatic applyStimulus(input aluVec_t v, output int cycles);
    clearImem();
    imem[0] = encI(6'h08, 0, 1, {{8{v.a[7]}}, v.a});
    imem[1] = encI(6'h08, 0, 2, {{8{v.b[7]}}, v.b});
    imem[2] = encR(3, 1, 2, v.funct);
    doReset();
    runUntilHalt(200, cycles);
  endtask

  // Instruction-level reference: executes the program architecturally and
  // totals the documented per-instruction cycle costs.
  task automatic modelRun(input int delay, output int cycles);
    logic [7:0]  pc, a, b, res, addr;
    logic [31:0] ins;
    logic [2:0]  rt, rd;
    bit          done;
    int          steps;
    pc = 8'd0;
    cycles = 0;
    done = 1'b0;
    steps = 0;
    while (!done && steps < 500) begin
      ins = imem[pc];
      pc = pc + 8'd1;
      steps++;
      a = mReg[ins[23:21]];
      b = mReg[ins[18:16]];
      rt = ins[18:16];
      rd = ins[13:11];
      addr = a + ins[7:0];
      res = 8'd0;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: done = 1'b1;
          endcase
          if (done) begin
            cycles += 2;
          end else begin
            cycles += 4;
            if (rd != 3'd0) mReg[rd] = res;
          end
        end
        6'h02: begin
          cycles += 2;
          pc = ins[7:0];
        end
        6'h04: begin
          cycles += 3;
          if (a == b) pc = pc + ins[7:0];
        end
        6'h08: begin
          cycles += 4;
          if (rt != 3'd0) mReg[rt] = a + ins[7:0];
        end
        6'h23: begin
          cycles += 5 + delay;
          if (rt != 3'd0) mReg[rt] = mMem[addr];
        end
        6'h2B: begin
          cycles += 4 + delay;
          mMem[addr] = b;
        end
        default: begin
          cycles += 2;
          done = 1'b1;
        end
      endcase
    end
  endtask

  initial begin
    int cyc;
    int expCyc;
    int bad;
    logic [7:0] v;
    logic [7:0] s0;
    logic [7:0] p0;

    clearImem();

    // ---------------- Test plan program: arithmetic then halt marker
    imem[0] = 32'h20010005;
    imem[1] = 32'h20020003;
    imem[2] = 32'h00221820;
    imem[3] = 32'h00222022;
    imem[4] = 32'h0041282A;
    doReset();
    checkOutput("reset_pc", 32'(imem_addr), 32'd0);
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    runUntilHalt(200, cyc);
    checkOutput("progA_cycles", cyc, 32'd22);
    checkOutput("progA_halted", 32'(halted), 32'd1);
    checkOutput("progA_illegal", 32'(illegal), 32'd1);
    checkOutput("progA_state", 32'(state_o), 32'd5);
    readReg(1, v); checkOutput("progA_R1", 32'(v), 32'd5);
    readReg(2, v); checkOutput("progA_R2", 32'(v), 32'd3);
    readReg(3, v); checkOutput("progA_R3", 32'(v), 32'd8);
    readReg(4, v); checkOutput("progA_R4", 32'(v), 32'd2);
    readReg(5, v); checkOutput("progA_R5", 32'(v), 32'd1);
    runCycles(3);
    checkOutput("halt_pc_frozen", 32'(imem_addr), 32'd6);
`ifdef MC_CORE_TRACE_EN
    checkOutput("trace_retires", retireCount, 32'd5);
    checkOutput("trace_retire_pc", retirePcBad, 32'd0);
    checkOutput("trace_icount", icount, 32'd5);
`endif

    // ---------------- Table of ALU vectors
    vecs[0] = '{8'h05, 8'h03, 6'h20, 8'h08, 14};
    vecs[1] = '{8'hF0, 8'h20, 6'h20, 8'h10, 14};
    vecs[2] = '{8'h03, 8'h05, 6'h22, 8'hFE, 14};
    vecs[3] = '{8'hCC, 8'hAA, 6'h24, 8'h88, 14};
    vecs[4] = '{8'hCC, 8'hAA, 6'h25, 8'hEE, 14};
    vecs[5] = '{8'h80, 8'h7F, 6'h2A, 8'h01, 14};
    vecs[6] = '{8'h7F, 8'h80, 6'h2A, 8'h00, 14};
    vecs[7] = '{8'h05, 8'h05, 6'h2A, 8'h00, 14};
    vecs[8] = '{8'h05, 8'h03, 6'h21, 8'h00, 10};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], cyc);
      checkOutput($sformatf("vec%0d_cycles", i), cyc, vecs[i].expCycles);
      readReg(3, v);
      checkOutput($sformatf("vec%0d_R3", i), 32'(v), 32'(vecs[i].expR3));
    end

    // ---------------- sw then lw with a 3-cycle ack delay
    clearImem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h20020003;
    imem[2] = 32'h00221820;
    imem[3] = 32'hAC030004;
    imem[4] = 32'h8C060004;
    ackDelay = 3;
    doReset();
    readReg(3, v); checkOutput("reset_clears_R3", 32'(v), 32'd0);
    runUntilHalt(300, cyc);
    checkOutput("mem_cycles", cyc, 32'd29);
    checkOutput("store_req_cycles", storeCycles, 32'd4);
    checkOutput("store_addr", 32'(storeAddr), 32'd4);
    checkOutput("store_wdata", 32'(storeData), 32'd8);
    checkOutput("store_stable", storeChanges, 32'd0);
    checkOutput("load_req_cycles", loadCycles, 32'd4);
    readReg(6, v); checkOutput("load_R6", 32'(v), 32'd8);
    ackDelay = 0;

    // ---------------- beq taken at PC 5, addi to $0
    clearImem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h20020003;
    imem[2] = 32'h20000009;
    imem[3] = 32'h20070001;
    imem[4] = 32'h20E70001;
    imem[5] = 32'h10210002;
    imem[6] = 32'h20040011;
    imem[7] = 32'h08000000;
    doReset();
    runCycles(23);
    checkOutput("beq_taken_pc", 32'(imem_addr), 32'd8);
    checkOutput("beq_taken_state", 32'(state_o), 32'd0);
    runUntilHalt(100, cyc);
    checkOutput("beq_taken_rest", cyc, 32'd2);
    readReg(0, v); checkOutput("R0_zero", 32'(v), 32'd0);
    readReg(4, v); checkOutput("beq_skipped_R4", 32'(v), 32'd0);
    readReg(7, v); checkOutput("addi_chain_R7", 32'(v), 32'd2);

    // ---------------- beq not taken, then j 0 at PC 7
    imem[5] = 32'h10220002;
    doReset();
    runCycles(23);
    checkOutput("beq_nt_pc", 32'(imem_addr), 32'd6);
    runCycles(4);
    checkOutput("pre_j_pc", 32'(imem_addr), 32'd7);
    runCycles(2);
    checkOutput("j_pc", 32'(imem_addr), 32'd0);
    checkOutput("j_state", 32'(state_o), 32'd0);
    run = 1'b0;
    readReg(4, v); checkOutput("beq_nt_R4", 32'(v), 32'h11);
    run = 1'b1;

    // ---------------- stall for 10 cycles in EXEC
    clearImem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h20020003;
    imem[2] = 32'h00221820;
    imem[3] = 32'h00222022;
    imem[4] = 32'h0041282A;
    doReset();
    runCycles(2);
    s0 = 8'(state_o);
    p0 = imem_addr;
    checkOutput("stall_pre_state", 32'(s0), 32'd2);
    run = 1'b0;
    runCycles(10);
    checkOutput("stall_state", 32'(state_o), 32'(s0));
    checkOutput("stall_pc", 32'(imem_addr), 32'(p0));
    run = 1'b1;
    runUntilHalt(200, cyc);
    checkOutput("stall_rest_cycles", cyc, 32'd20);
    readReg(3, v); checkOutput("stall_R3", 32'(v), 32'd8);
    readReg(5, v); checkOutput("stall_R5", 32'(v), 32'd1);

    // ---------------- stall in MEM with ack present: ack must be ignored
    clearImem();
    imem[0] = 32'h20010007;
    imem[1] = 32'hAC010009;
    imem[2] = 32'h8C020009;
    ackDelay = 0;
    doReset();
    runCycles(7);
    checkOutput("mem_state", 32'(state_o), 32'd3);
    run = 1'b0;
    runCycles(3);
    checkOutput("mem_stall_state", 32'(state_o), 32'd3);
    checkOutput("mem_stall_req", 32'(dmem_req), 32'd1);
    checkOutput("mem_stall_we", 32'(dmem_we), 32'd1);
    run = 1'b1;
    runUntilHalt(100, cyc);
    checkOutput("mem_stall_rest", cyc, 32'd8);
    readReg(2, v); checkOutput("mem_stall_R2", 32'(v), 32'd7);

    // ---------------- reset while a request is pending
    ackDelay = 20;
    doReset();
    runCycles(7);
    checkOutput("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_pc", 32'(imem_addr), 32'd0);
    checkOutput("rst_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    ackDelay = 0;

    // ---------------- random programs against the reference model
    for (int p = 0; p < 40; p++) begin
      int len;
      int kind;
      clearImem();
      len = $urandom_range(6, 14);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1, 2: imem[i] = encI(6'h08, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
          3, 4, 5: begin
            logic [5:0] fns [5];
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            imem[i] = encR($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                           fns[$urandom_range(0, 4)]);
          end
          6: imem[i] = encI(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 31)));
          7: imem[i] = encI(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 31)));
          8: imem[i] = encI(6'h04, $urandom_range(0, 7), $urandom_range(0, 7),
                            16'($urandom_range(0, len - i - 1)));
          default: begin
            if ($urandom_range(0, 3) == 0) imem[i] = encR(3, 1, 2, 6'h21);
            else imem[i] = encI(6'h08, 0, $urandom_range(1, 7), 16'($urandom));
          end
        endcase
      end
      ackDelay = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
      for (int i = 0; i < 256; i++) mMem[i] = 8'h00;
      modelRun(ackDelay, expCyc);
      doReset();
      runUntilHalt(1000, cyc);
      checkOutput($sformatf("rnd%0d_cycles", p), cyc, expCyc);
      checkOutput($sformatf("rnd%0d_halted", p), 32'(halted), 32'd1);
      for (int r = 0; r < 8; r++) begin
        readReg(r, v);
        checkOutput($sformatf("rnd%0d_R%0d", p, r), 32'(v), 32'(mReg[r]));
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== mMem[i]) bad++;
      checkOutput($sformatf("rnd%0d_dmem", p), bad, 32'd0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
